// File: rtl/ndro_ctrl_pkg.sv
// Shared types and constants for the NDRO cell sequencer.
package ndro_ctrl_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam logic [7:0]  ERR_MAX = 8'hFF;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_READ  = 2'b11
  } ndro_op_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_WAIT,
    ST_RESP
  } ndro_state_t;

endpackage

// File: rtl/ndro_gap_timer.sv
// Loadable down-counter; done flags a count of zero. Shared by the GAP and WAIT phases.
module ndro_gap_timer
  import ndro_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ndro_sequencer.sv
// Command sequencer for one basic_ndro cell: spaced set/reset/clk pulses, timed
// read-back with response handshake, and shadow-bit consistency tracking.
module ndro_sequencer
  import ndro_ctrl_pkg::*;
#(
  parameter int unsigned SEP_CYCLES = 2,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_data,
  output logic       ndro_set,
  output logic       ndro_reset,
  output logic       ndro_clk,
  input  logic       ndro_out,
  output logic       shadow,
  output logic       mismatch,
  output logic [7:0] err_count
);

  localparam logic [CNT_W-1:0] SEP_LOAD   = (SEP_CYCLES == 0) ? '0 : CNT_W'(SEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(READ_LAT - 1);
  localparam ndro_state_t      POST_STATE = (SEP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  ndro_state_t      state_q, state_d;
  ndro_op_t         op_q, op_d;
  logic             shadow_q, shadow_d;
  logic             rsp_data_q, rsp_data_d;
  logic             mismatch_q, mismatch_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             ndro_set_q, ndro_set_d;
  logic             ndro_reset_q, ndro_reset_d;
  logic             ndro_clk_q, ndro_clk_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  ndro_gap_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    shadow_d    = shadow_q;
    rsp_data_d  = rsp_data_q;
    mismatch_d  = mismatch_q;
    err_count_d = err_count_q;
    tmr_load    = 1'b0;
    tmr_val     = SEP_LOAD;

    unique case (state_q)
      ST_INIT: begin
        state_d = ST_PULSE;
        op_d    = OP_RESET;
      end
      // req_ready is high exactly while in IDLE, so req_valid alone is the handshake
      ST_IDLE: begin
        if (req_valid && (ndro_op_t'(req_op) != OP_NOP)) begin
          state_d = ST_PULSE;
          op_d    = ndro_op_t'(req_op);
        end
      end
      ST_PULSE: begin
        if (op_q == OP_SET) begin
          shadow_d = 1'b1;
        end else if (op_q == OP_RESET) begin
          shadow_d = 1'b0;
        end
        tmr_load = 1'b1;
        if (op_q == OP_READ) begin
          state_d = ST_WAIT;
          tmr_val = LAT_LOAD;
        end else begin
          state_d = POST_STATE;
        end
      end
      ST_WAIT: begin
        if (tmr_done) begin
          state_d    = ST_RESP;
          rsp_data_d = ndro_out;
          if (ndro_out != shadow_q) begin
            mismatch_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + 8'd1;
            end
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d  = POST_STATE;
          tmr_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Outputs are registered views of the next state
    req_ready_d  = (state_d == ST_IDLE);
    rsp_valid_d  = (state_d == ST_RESP);
    ndro_set_d   = (state_d == ST_PULSE) && (op_d == OP_SET);
    ndro_reset_d = (state_d == ST_PULSE) && (op_d == OP_RESET);
    ndro_clk_d   = (state_d == ST_PULSE) && (op_d == OP_READ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      op_q         <= OP_NOP;
      shadow_q     <= 1'b0;
      rsp_data_q   <= 1'b0;
      mismatch_q   <= 1'b0;
      err_count_q  <= 8'd0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      ndro_set_q   <= 1'b0;
      ndro_reset_q <= 1'b0;
      ndro_clk_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      shadow_q     <= shadow_d;
      rsp_data_q   <= rsp_data_d;
      mismatch_q   <= mismatch_d;
      err_count_q  <= err_count_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      ndro_set_q   <= ndro_set_d;
      ndro_reset_q <= ndro_reset_d;
      ndro_clk_q   <= ndro_clk_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign ndro_set   = ndro_set_q;
  assign ndro_reset = ndro_reset_q;
  assign ndro_clk   = ndro_clk_q;
  assign shadow     = shadow_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ndro_sequencer.sv
// Directed bench for ndro_sequencer (SEP_CYCLES=2, READ_LAT=1) with a behavioural NDRO cell.
module tb_ndro_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_data;
  logic       ndro_set, ndro_reset, ndro_clk, ndro_out;
  logic       shadow, mismatch;
  logic [7:0] err_count;

  logic cell_q = 1'b0;
  logic force_en = 1'b0;
  logic force_val = 1'b0;
  logic prev_pulse = 1'b0;
  int   cyc = 0;
  int   pulse_viol = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ndro_sequencer #(.SEP_CYCLES(2), .READ_LAT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .ndro_set   (ndro_set),
    .ndro_reset (ndro_reset),
    .ndro_clk   (ndro_clk),
    .ndro_out   (ndro_out),
    .shadow     (shadow),
    .mismatch   (mismatch),
    .err_count  (err_count)
  );

  // Cycle k is the interval after the k-th rising edge following reset release
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Behavioural cell: set/reset store a bit, reads are non-destructive
  always @(posedge clk) begin
    if (ndro_set)        cell_q <= 1'b1;
    else if (ndro_reset) cell_q <= 1'b0;
  end
  assign ndro_out = force_en ? force_val : cell_q;

  always @(negedge clk) begin
    if (reset) begin
      prev_pulse <= 1'b0;
    end else begin
      if ((ndro_set & ndro_reset) | (ndro_set & ndro_clk) | (ndro_reset & ndro_clk) |
          (prev_pulse & (ndro_set | ndro_reset | ndro_clk)))
        pulse_viol <= pulse_viol + 1;
      prev_pulse <= ndro_set | ndro_reset | ndro_clk;
    end
  end

  task automatic wait_cycle(input int k);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc != k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      checks++; errors++;
      $display("FAIL wait_cycle: cycle=%0d expected %0d", cyc, k);
    end
  endtask

  task automatic test_init_release(input string tag);
    for (int c = 1; c <= 4; c++) begin
      wait_cycle(c);
      checks++;
      if (ndro_reset !== 1'(c == 1)) begin errors++; $display("FAIL %s ndro_reset c%0d: got %0b expected %0b", tag, c, ndro_reset, c == 1); end
      checks++;
      if (req_ready !== 1'(c == 4)) begin errors++; $display("FAIL %s req_ready c%0d: got %0b expected %0b", tag, c, req_ready, c == 4); end
      checks++;
      if (rsp_valid !== 1'b0 || ndro_set !== 1'b0 || ndro_clk !== 1'b0) begin errors++; $display("FAIL %s quiet c%0d: rsp_valid=%0b set=%0b clk=%0b expected 0", tag, c, rsp_valid, ndro_set, ndro_clk); end
    end
    checks++;
    if (shadow !== 1'b0) begin errors++; $display("FAIL %s shadow: got %0b expected 0", tag, shadow); end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, ndro_set, ndro_reset, ndro_clk, shadow, mismatch} !== 8'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b rv=%0b rd=%0b s=%0b r=%0b c=%0b sh=%0b mm=%0b ec=%0d expected all 0",
               req_ready, rsp_valid, rsp_data, ndro_set, ndro_reset, ndro_clk, shadow, mismatch, err_count);
    end
    reset = 1'b0;
    test_init_release("init");
  endtask

  task automatic test_set();
    wait_cycle(10);
    req_valid = 1'b1; req_op = 2'b01;
    checks++; if (ndro_set !== 1'b0) begin errors++; $display("FAIL set_pre c10: ndro_set=%0b expected 0", ndro_set); end
    wait_cycle(11);
    req_valid = 1'b0; req_op = 2'b00;
    checks++; if (ndro_set !== 1'b1) begin errors++; $display("FAIL set_pulse c11: ndro_set=%0b expected 1", ndro_set); end
    checks++; if (shadow !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL set c11: shadow=%0b req_ready=%0b expected 0 0", shadow, req_ready); end
    wait_cycle(12);
    checks++; if (ndro_set !== 1'b0 || shadow !== 1'b1) begin errors++; $display("FAIL set c12: ndro_set=%0b shadow=%0b expected 0 1", ndro_set, shadow); end
    wait_cycle(13);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL set_gap c13: req_ready=%0b expected 0", req_ready); end
    wait_cycle(14);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL set_ready c14: req_ready=%0b expected 1", req_ready); end
  endtask

  task automatic test_read();
    wait_cycle(20);
    req_valid = 1'b1; req_op = 2'b11;
    wait_cycle(21);
    req_valid = 1'b0; req_op = 2'b00;
    checks++; if (ndro_clk !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL read c21: ndro_clk=%0b rsp_valid=%0b expected 1 0", ndro_clk, rsp_valid); end
    wait_cycle(22);
    checks++; if (ndro_clk !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL read c22: ndro_clk=%0b rsp_valid=%0b expected 0 0", ndro_clk, rsp_valid); end
    wait_cycle(23);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 1'b1 || mismatch !== 1'b0) begin errors++; $display("FAIL read c23: rsp_valid=%0b rsp_data=%0b mismatch=%0b expected 1 1 0", rsp_valid, rsp_data, mismatch); end
    wait_cycle(25);
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL read_gap c25: req_ready=%0b rsp_valid=%0b expected 0 0", req_ready, rsp_valid); end
    wait_cycle(26);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL read_ready c26: req_ready=%0b expected 1", req_ready); end
  endtask

  task automatic test_mismatch();
    wait_cycle(30);
    force_en = 1'b1; force_val = 1'b0;
    req_valid = 1'b1; req_op = 2'b11;
    wait_cycle(31);
    req_valid = 1'b0; req_op = 2'b00;
    wait_cycle(33);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 1'b0) begin errors++; $display("FAIL mm1 c33: rsp_valid=%0b rsp_data=%0b expected 1 0", rsp_valid, rsp_data); end
    checks++; if (mismatch !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL mm1 flag: mismatch=%0b err_count=%0d expected 1 1", mismatch, err_count); end
    wait_cycle(40);
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_sticky c40: mismatch=%0b expected 1", mismatch); end
    req_valid = 1'b1; req_op = 2'b11;
    wait_cycle(41);
    req_valid = 1'b0; req_op = 2'b00;
    wait_cycle(43);
    checks++; if (rsp_data !== 1'b0 || err_count !== 8'd2) begin errors++; $display("FAIL mm2 c43: rsp_data=%0b err_count=%0d expected 0 2", rsp_data, err_count); end
    wait_cycle(44);
    force_en = 1'b0;
  endtask

  task automatic test_backpressure();
    wait_cycle(50);
    req_valid = 1'b1; req_op = 2'b11; rsp_ready = 1'b0;
    wait_cycle(51);
    req_valid = 1'b0; req_op = 2'b00;
    for (int c = 53; c <= 57; c++) begin
      wait_cycle(c);
      req_valid = 1'b1; req_op = 2'b01;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 1'b1 || req_ready !== 1'b0 || {ndro_set, ndro_reset, ndro_clk} !== 3'b000) begin
        errors++;
        $display("FAIL bp_hold c%0d: rv=%0b rd=%0b rdy=%0b pulses=%03b expected 1 1 0 000", c, rsp_valid, rsp_data, req_ready, {ndro_set, ndro_reset, ndro_clk});
      end
    end
    wait_cycle(58);
    req_valid = 1'b0; req_op = 2'b00; rsp_ready = 1'b1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 1'b1) begin errors++; $display("FAIL bp c58: rsp_valid=%0b rsp_data=%0b expected 1 1", rsp_valid, rsp_data); end
    wait_cycle(59);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || ndro_set !== 1'b0) begin errors++; $display("FAIL bp_gap c59: rv=%0b rdy=%0b set=%0b expected 0 0 0", rsp_valid, req_ready, ndro_set); end
    wait_cycle(60);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_gap c60: req_ready=%0b expected 0", req_ready); end
    wait_cycle(61);
    checks++; if (req_ready !== 1'b1 || err_count !== 8'd2) begin errors++; $display("FAIL bp_idle c61: req_ready=%0b err_count=%0d expected 1 2", req_ready, err_count); end
  endtask

  task automatic test_reset_mid();
    wait_cycle(70);
    req_valid = 1'b1; req_op = 2'b11;
    wait_cycle(71);
    req_valid = 1'b0; req_op = 2'b00;
    checks++; if (ndro_clk !== 1'b1) begin errors++; $display("FAIL rm_clk c71: ndro_clk=%0b expected 1", ndro_clk); end
    wait_cycle(72);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, ndro_set, ndro_reset, ndro_clk, shadow, mismatch} !== 8'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL rm_async: rdy=%0b rv=%0b rd=%0b s=%0b r=%0b c=%0b sh=%0b mm=%0b ec=%0d expected all 0",
               req_ready, rsp_valid, rsp_data, ndro_set, ndro_reset, ndro_clk, shadow, mismatch, err_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_norsp %0d: rsp_valid=%0b expected 0", i, rsp_valid); end
    end
    reset = 1'b0;
    test_init_release("reinit");
  endtask

  task automatic test_nop();
    wait_cycle(10);
    req_valid = 1'b1; req_op = 2'b00;
    wait_cycle(11);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || {ndro_set, ndro_reset, ndro_clk} !== 3'b000) begin
      errors++; $display("FAIL nop c11: req_ready=%0b pulses=%03b expected 1 000", req_ready, {ndro_set, ndro_reset, ndro_clk});
    end
  endtask

  task automatic test_back_to_back();
    wait_cycle(12);
    req_valid = 1'b1; req_op = 2'b01;
    wait_cycle(13);
    req_op = 2'b10;
    checks++; if (ndro_set !== 1'b1) begin errors++; $display("FAIL b2b_set c13: ndro_set=%0b expected 1", ndro_set); end
    wait_cycle(14);
    checks++; if (shadow !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b c14: shadow=%0b req_ready=%0b expected 1 0", shadow, req_ready); end
    wait_cycle(16);
    checks++; if (req_ready !== 1'b1 || ndro_reset !== 1'b0) begin errors++; $display("FAIL b2b c16: req_ready=%0b ndro_reset=%0b expected 1 0", req_ready, ndro_reset); end
    wait_cycle(17);
    req_valid = 1'b0; req_op = 2'b00;
    checks++; if (ndro_reset !== 1'b1 || shadow !== 1'b1) begin errors++; $display("FAIL b2b c17: ndro_reset=%0b shadow=%0b expected 1 1", ndro_reset, shadow); end
    wait_cycle(18);
    checks++; if (ndro_reset !== 1'b0 || shadow !== 1'b0) begin errors++; $display("FAIL b2b c18: ndro_reset=%0b shadow=%0b expected 0 0", ndro_reset, shadow); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_read();
    test_mismatch();
    test_backpressure();
    test_reset_mid();
    test_nop();
    test_back_to_back();
    wait_cycle(24);
    checks++;
    if (pulse_viol !== 0) begin errors++; $display("FAIL pulse_rules: violations=%0d expected 0", pulse_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
